// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: walks a 2-input gate under test through its truth table
// in hardware and checks each result against an expected table.
//
// Vectors run in the order {I0,I1} = 00, 01, 10, 11 (I0 is the MSB of the
// index). Each vector is held for SETTLE_CYCLES cycles and sampled in the
// cycle after that, so one vector takes SETTLE_CYCLES+1 cycles.
//
// Parameters:
//   SETTLE_CYCLES  cycles I0/I1 are held before Out is sampled (1..15)
//   EXP_TT         expected Out per vector, bit k for vector k (default XNOR)
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          begin a run; only looked at while idle
//   Out            output of the gate under test
//   I0, I1         registered drive to the gate under test
//   busy           high from the start-accept edge until the done cycle ends
//   done           one-cycle completion pulse
//   pass           no mismatches in the last run; valid from done until next start
//   fail_count     number of mismatching vectors (0..4)
//   vec_idx        index of the vector currently driven
//   err_mask       (GATE_TT_ERR_MASK_EN only) bit k set when vector k mismatched
//
// Optional build macro: GATE_TT_ERR_MASK_EN adds the err_mask port and logic.

module gate_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  EXP_TT        = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       Out,
  output logic       I0,
  output logic       I1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_count,
  output logic [1:0] vec_idx
`ifdef GATE_TT_ERR_MASK_EN
  ,
  output logic [3:0] err_mask
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VEC_W = 2;
  localparam int unsigned FC_W  = 3;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [VEC_W-1:0]  drive_q, drive_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mismatch_c;
`ifdef GATE_TT_ERR_MASK_EN
  logic [3:0]        mask_q, mask_d;
`endif

  // Case-inequality so an X or Z on Out is treated as a failure.
  assign mismatch_c = (Out !== EXP_TT[vec_q]);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      drive_q <= '0;
      fc_q    <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GATE_TT_ERR_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      drive_q <= drive_d;
      fc_q    <= fc_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef GATE_TT_ERR_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    drive_d = drive_q;
    fc_d    = fc_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef GATE_TT_ERR_MASK_EN
    mask_d  = mask_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          drive_d = '0;
          vec_d   = '0;
          fc_d    = '0;
          pass_d  = 1'b0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
`ifdef GATE_TT_ERR_MASK_EN
          mask_d  = '0;
`endif
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (mismatch_c) begin
          fc_d = fc_q + FC_W'(1);
`ifdef GATE_TT_ERR_MASK_EN
          mask_d[vec_q] = 1'b1;
`endif
        end
        if (vec_q == VEC_LAST) begin
          // pass and done land together on entry to DONE.
          done_d  = 1'b1;
          pass_d  = (fc_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          drive_d = vec_q + VEC_W'(1);
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign I0         = drive_q[1];
  assign I1         = drive_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fc_q;
  assign vec_idx    = vec_q;
`ifdef GATE_TT_ERR_MASK_EN
  assign err_mask   = mask_q;
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Testbench for gate_tt_sequencer: two instances (SETTLE_CYCLES=1 and 3) each
// driven by a behavioural gate whose truth table and X-injected vectors are
// chosen per run. Expected results come from the truth-table rules: a vector
// fails when the gate output differs from EXP_TT or is X, and with a period of
// SETTLE_CYCLES+1 cycles per vector, done is sampled high by edge
// 4*(SETTLE_CYCLES+1)+1 counted from the start-accept edge.

module tb_gate_tt_sequencer;

  localparam logic [3:0] EXP = 4'b1001;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;

  logic       clk;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] gout;
  logic [1:0] i0, i1, busy, done, pass;
  logic [2:0] fc0, fc1;
  logic [1:0] vi0, vi1;
`ifdef GATE_TT_ERR_MASK_EN
  logic [3:0] em0, em1;
`endif
  logic [3:0] gut_tt0, gut_tt1, gut_xm0, gut_xm1;

  int checks = 0;
  int passes = 0;

  gate_tt_sequencer #(.SETTLE_CYCLES(1), .EXP_TT(EXP)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .Out(gout[0]),
    .I0(i0[0]), .I1(i1[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_count(fc0), .vec_idx(vi0)
`ifdef GATE_TT_ERR_MASK_EN
    , .err_mask(em0)
`endif
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(3), .EXP_TT(EXP)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .Out(gout[1]),
    .I0(i0[1]), .I1(i1[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_count(fc1), .vec_idx(vi1)
`ifdef GATE_TT_ERR_MASK_EN
    , .err_mask(em1)
`endif
  );

  // Behavioural gates under test.
  assign gout[0] = gut_xm0[{i0[0], i1[0]}] ? 1'bx : gut_tt0[{i0[0], i1[0]}];
  assign gout[1] = gut_xm1[{i0[1], i1[1]}] ? 1'bx : gut_tt1[{i0[1], i1[1]}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: vectors that fail are those differing from EXP or X.
  function automatic logic [3:0] ref_mask(input logic [3:0] tt, input logic [3:0] xm);
    return (tt ^ EXP) | xm;
  endfunction

  function automatic logic [2:0] ref_fc(input logic [3:0] tt, input logic [3:0] xm);
    logic [3:0] m;
    m = ref_mask(tt, xm);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  function automatic logic [2:0] fc_of(input int inst);
    return (inst == 0) ? fc0 : fc1;
  endfunction

  function automatic logic [1:0] vi_of(input int inst);
    return (inst == 0) ? vi0 : vi1;
  endfunction

  function automatic logic [3:0] em_of(input int inst);
`ifdef GATE_TT_ERR_MASK_EN
    return (inst == 0) ? em0 : em1;
`else
    return (inst == 0) ? 4'b0000 : 4'b0000;
`endif
  endfunction

  // Drives one run and records what was observed; the callers compare.
  // junk_k: cycle index after which start is re-pulsed while busy (-1 = none).
  task automatic run_once(input int inst, input logic [3:0] tt, input logic [3:0] xm,
                          input int junk_k,
                          output int done_edge, output int seq_errs, output int done_pulses,
                          output logic [2:0] fc_done, output logic pass_done,
                          output logic [3:0] em_done,
                          output logic [2:0] fc_first, output logic pass_first);
    int per;
    int last;
    int exp_vec;
    logic exp_busy;
    per  = (inst == 0) ? 2 : 4;
    last = 4 * per;
    if (inst == 0) begin gut_tt0 = tt; gut_xm0 = xm; end
    else           begin gut_tt1 = tt; gut_xm1 = xm; end
    done_edge = -1; seq_errs = 0; done_pulses = 0;
    fc_done = '0; pass_done = 1'b0; em_done = '0; fc_first = '1; pass_first = 1'b1;
    @(negedge clk);
    start[inst] = 1'b1;
    @(posedge clk);                       // start-accept edge 0
    for (int k = 0; k <= last + 1; k++) begin
      @(negedge clk);                     // observe state after edge k
      start[inst] = (k == junk_k);
      exp_vec  = (k < last) ? k / per : 3;
      exp_busy = (k <= last);
      if ({i0[inst], i1[inst]} !== 2'(exp_vec)) seq_errs++;
      if (vi_of(inst) !== 2'(exp_vec)) seq_errs++;
      if (busy[inst] !== exp_busy) seq_errs++;
      if (k == 0) begin
        fc_first = fc_of(inst);
        pass_first = pass[inst];
      end
      if (done[inst] === 1'b1) begin
        done_pulses++;
        if (done_edge < 0) begin
          done_edge = k + 1;
          fc_done   = fc_of(inst);
          pass_done = pass[inst];
          em_done   = em_of(inst);
        end
      end
    end
    start[inst] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 2'b00;
    gut_tt0 = TT_XNOR; gut_tt1 = TT_XNOR; gut_xm0 = '0; gut_xm1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i0[0], i1[0], busy[0], done[0], pass[0]} !== 5'b0) $display("FAIL reset_bits got=%b want=00000", {i0[0], i1[0], busy[0], done[0], pass[0]});
    else passes++;
    checks++;
    if ({fc0, vi0} !== 5'b0) $display("FAIL reset_counts fc=%0d vec=%0d want 0/0", fc0, vi0);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy[0], done[0], busy[1], done[1]} !== 4'b0) $display("FAIL idle_after_reset got=%b want=0000", {busy[0], done[0], busy[1], done[1]});
    else passes++;
  endtask

  // Fixed-gate scenarios on the SETTLE_CYCLES=1 instance.
  task automatic test_gate(input string name, input logic [3:0] tt);
    int de, se, dp;
    logic [2:0] fcd, fcf;
    logic pd, pf;
    logic [3:0] emd;
    run_once(0, tt, 4'b0000, -1, de, se, dp, fcd, pd, emd, fcf, pf);
    checks++;
    if (se != 0 || dp != 1) $display("FAIL %s_sequence seq_errs=%0d done_pulses=%0d want 0/1", name, se, dp);
    else passes++;
    checks++;
    if (de != 9) $display("FAIL %s_done_edge got=%0d want=9", name, de);
    else passes++;
    checks++;
    if (fcd !== ref_fc(tt, 4'b0000) || pd !== (ref_fc(tt, 4'b0000) == 3'd0))
      $display("FAIL %s_result fc=%0d pass=%b want fc=%0d pass=%b", name, fcd, pd,
               ref_fc(tt, 4'b0000), (ref_fc(tt, 4'b0000) == 3'd0));
    else passes++;
`ifdef GATE_TT_ERR_MASK_EN
    checks++;
    if (emd !== ref_mask(tt, 4'b0000)) $display("FAIL %s_err_mask got=%b want=%b", name, emd, ref_mask(tt, 4'b0000));
    else passes++;
`endif
  endtask

  task automatic test_start_while_busy;
    int de, se, dp;
    logic [2:0] fcd, fcf;
    logic pd, pf;
    logic [3:0] emd;
    // Re-pulse start in the SETTLE of vector 2 (after edge 4).
    run_once(0, TT_AND, 4'b0000, 4, de, se, dp, fcd, pd, emd, fcf, pf);
    checks++;
    if (se != 0 || dp != 1 || de != 9) $display("FAIL busy_start_run seq_errs=%0d pulses=%0d done_edge=%0d want 0/1/9", se, dp, de);
    else passes++;
    checks++;
    if (fcd !== 3'd1 || pd !== 1'b0) $display("FAIL busy_start_result fc=%0d pass=%b want 1/0", fcd, pd);
    else passes++;
    run_once(0, TT_XNOR, 4'b0000, -1, de, se, dp, fcd, pd, emd, fcf, pf);
    checks++;
    if (fcf !== 3'd0) $display("FAIL restart_clears_fc got=%0d want=0", fcf);
    else passes++;
    run_once(0, TT_AND, 4'b0000, -1, de, se, dp, fcd, pd, emd, fcf, pf);
    checks++;
    if (pf !== 1'b0) $display("FAIL restart_clears_pass got=%b want=0", pf);
    else passes++;
  endtask

  task automatic test_reset_mid_run;
    int de, se, dp, stray;
    logic [2:0] fcd, fcf;
    logic pd, pf;
    logic [3:0] emd;
    gut_tt0 = TT_AND; gut_xm0 = '0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);                       // vector 1 now driven, vector 0 failed
    checks++;
    if (fc0 !== 3'd1 || {i0[0], i1[0]} !== 2'b01) $display("FAIL pre_reset fc=%0d vec=%b want 1/01", fc0, {i0[0], i1[0]});
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i0[0], i1[0], busy[0]} !== 3'b0 || fc0 !== 3'd0 || vi0 !== 2'd0)
      $display("FAIL async_reset i0i1busy=%b fc=%0d vec=%0d want 000/0/0", {i0[0], i1[0], busy[0]}, fc0, vi0);
    else passes++;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      if (done[0] === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) $display("FAIL no_done_after_reset pulses=%0d want=0", stray);
    else passes++;
    run_once(0, TT_XNOR, 4'b0000, -1, de, se, dp, fcd, pd, emd, fcf, pf);
    checks++;
    if (se != 0 || dp != 1 || de != 9 || fcd !== 3'd0 || pd !== 1'b1)
      $display("FAIL post_reset_run seq=%0d pulses=%0d edge=%0d fc=%0d pass=%b want 0/1/9/0/1", se, dp, de, fcd, pd);
    else passes++;
  endtask

  task automatic test_x_settle3;
    int de, se, dp;
    logic [2:0] fcd, fcf;
    logic pd, pf;
    logic [3:0] emd;
    run_once(1, TT_XNOR, 4'b1000, -1, de, se, dp, fcd, pd, emd, fcf, pf);
    checks++;
    if (de != 17 || se != 0 || dp != 1) $display("FAIL x_settle3_timing edge=%0d seq=%0d pulses=%0d want 17/0/1", de, se, dp);
    else passes++;
    checks++;
    if (fcd !== 3'd1 || pd !== 1'b0) $display("FAIL x_settle3_result fc=%0d pass=%b want 1/0", fcd, pd);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int last;
    int errs;
    int got_done;
    last = 8;
    errs = 0;
    gut_tt0 = TT_XNOR; gut_xm0 = '0;
    @(negedge clk);
    start[0] = 1'b1;                      // held high across two runs
    @(posedge clk);
    for (int k = 0; k <= last + 2; k++) begin
      @(negedge clk);
      if (k <= last && busy[0] !== 1'b1) errs++;
      if (k == last + 1 && busy[0] !== 1'b0) errs++;
      if (k == last + 2 && (busy[0] !== 1'b1 || {i0[0], i1[0]} !== 2'b00)) errs++;
    end
    start[0] = 1'b0;
    checks++;
    if (errs != 0) $display("FAIL back_to_back_gap errors=%0d want=0", errs);
    else passes++;
    got_done = 0;
    for (int k = 0; k < 20 && got_done == 0; k++) begin
      @(negedge clk);
      if (done[0] === 1'b1) got_done = 1;
    end
    checks++;
    if (got_done != 1) $display("FAIL back_to_back_second_done got=%0d want=1", got_done);
    else passes++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    int de, se, dp, inst, per, junk;
    logic [2:0] fcd, fcf;
    logic pd, pf;
    logic [3:0] emd, tt, xm;
    for (int n = 0; n < 16; n++) begin
      inst = int'($urandom_range(0, 1));
      per  = (inst == 0) ? 2 : 4;
      tt   = 4'($urandom);
      xm   = 4'($urandom) & EXP;          // X only where a 1 is expected
      junk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4 * per)) : -1;
      run_once(inst, tt, xm, junk, de, se, dp, fcd, pd, emd, fcf, pf);
      checks++;
      if (se != 0 || dp != 1 || de != 4 * per + 1)
        $display("FAIL rand%0d_timing inst=%0d seq=%0d pulses=%0d edge=%0d want 0/1/%0d", n, inst, se, dp, de, 4 * per + 1);
      else passes++;
      checks++;
      if (fcd !== ref_fc(tt, xm) || pd !== (ref_fc(tt, xm) == 3'd0))
        $display("FAIL rand%0d_result tt=%b xm=%b fc=%0d pass=%b want %0d/%b", n, tt, xm, fcd, pd,
                 ref_fc(tt, xm), (ref_fc(tt, xm) == 3'd0));
      else passes++;
`ifdef GATE_TT_ERR_MASK_EN
      checks++;
      if (emd !== ref_mask(tt, xm)) $display("FAIL rand%0d_err_mask got=%b want=%b", n, emd, ref_mask(tt, xm));
      else passes++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_gate("xnor", TT_XNOR);
    test_gate("and", TT_AND);
    test_gate("or", TT_OR);
    test_start_while_busy();
    test_reset_mid_run();
    test_x_settle3();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
